// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating-priority pick for the 4:1 mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // First set request at or after last+1, wrapping; returns last if none is set.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_bit.sv
// Combinational 4:1 bit-select datapath, forced low when no grant is active.
module mux4_bit
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] data_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               en_i,
    output logic               y_o
);

    assign y_o = en_i & data_i[sel_i];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer: one grant at a time, bounded hold, one dead cycle between grants.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic               y
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   pick_s;

    assign pick_s = rr_pick(req, last_q);

    // Next-state logic: arbitrate from IDLE/RELEASE, count and end grants in GRANT.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RELEASE: begin
                if (ena && (|req)) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick_s;
                    sel_d   = pick_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            GRANT: begin
                // A single exit even when several end conditions coincide.
                if (!req[sel_q] || (cnt_q == HOLD_LAST) || !ena) begin
                    state_d = RELEASE;
                    gnt_d   = 4'b0000;
                    last_d  = sel_q;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = |gnt_q;

    mux4_bit u_mux4_bit (
        .data_i (data),
        .sel_i  (sel_q),
        .en_i   (valid),
        .y_o    (y)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: HOLD_MAX=8 and HOLD_MAX=1 instances against a rule-level model.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [3:0] req, data;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b, y_a, y_b;
    logic       rand_data;

    int ncmp = 0;
    int nerr = 0;

    int m_owner [2];
    int m_held  [2];
    int m_last  [2];
    int m_sel   [2];
    int m_hold  [2] = '{8, 1};

    always #5 clk = ~clk;

    mux_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .data(data),
        .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .y(y_a)
    );

    mux_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .data(data),
        .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .y(y_b)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_held[m]  = 0;
            m_last[m]  = 3;
            m_sel[m]   = 0;
        end
    endtask

    // One rising edge: a grant continues while requested, enabled and under its hold limit.
    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            if (m_owner[m] >= 0) begin
                if (!req[m_owner[m]] || !ena || m_held[m] == m_hold[m]) begin
                    m_last[m]  = m_owner[m];
                    m_owner[m] = -1;
                end else begin
                    m_held[m]++;
                end
            end else if (ena && req != 4'b0000) begin
                m_owner[m] = pick(req, m_last[m]);
                m_held[m]  = 1;
                m_sel[m]   = m_owner[m];
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] og, eg;
        logic [1:0] os;
        logic       ov, oy, ev, ey;
        for (int m = 0; m < 2; m++) begin
            og = (m == 0) ? gnt_a   : gnt_b;
            os = (m == 0) ? sel_a   : sel_b;
            ov = (m == 0) ? valid_a : valid_b;
            oy = (m == 0) ? y_a     : y_b;
            ev = (m_owner[m] >= 0);
            eg = ev ? (4'b0001 << m_owner[m]) : 4'b0000;
            ey = ev ? data[m_sel[m]] : 1'b0;
            check($sformatf("gnt[%0d]", m),     og,              eg);
            check($sformatf("sel[%0d]", m),     {2'b00, os},     4'(m_sel[m]));
            check($sformatf("valid[%0d]", m),   {3'b000, ov},    {3'b000, ev});
            check($sformatf("y[%0d]", m),       {3'b000, oy},    {3'b000, ey});
            check($sformatf("onehot0[%0d]", m), {3'b000, $onehot0(og)}, 4'b0001);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_clock();
            else       model_reset();
            #1;
            check_outputs();
            if (rand_data) data = 4'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; req = 4'b1111; data = 4'b0000; rand_data = 1'b1;
        model_reset();
        #12;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full contention after reset: 0,1,2,3,0 with gaps.
        step(1);
        check("t1_first_gnt", gnt_a, 4'b0001);
        step(45);

        // Single short request of three cycles with a fixed data pattern.
        req = 4'b0000; step(3);
        rand_data = 1'b0; data = 4'b0100; req = 4'b0100;
        step(1);
        check("t2_gnt", gnt_a, 4'b0100);
        check("t2_y", {3'b000, y_a}, 4'b0001);
        step(2);
        req = 4'b0000; step(4);

        // Lone requester held: hold-limited bursts with one-cycle gaps.
        rand_data = 1'b1; req = 4'b0010; step(30);

        // Enable drops mid-grant, then rotation resumes from requester 0.
        req = 4'b0000; step(3);
        req = 4'b0001; step(3);
        ena = 1'b0; step(1);
        check("t4_ena_off", gnt_a, 4'b0000);
        req = 4'b1111; step(4);
        ena = 1'b1; req = 4'b0011; step(1); step(1);
        check("t4_resume", gnt_a, 4'b0010);
        step(4);

        // Asynchronous reset in the middle of a grant to requester 2.
        req = 4'b0000; step(3);
        req = 4'b0100; step(4);
        rst_n = 1'b0; #1;
        model_reset();
        check_outputs();
        step(2);
        rst_n = 1'b1; req = 4'b1111;
        step(1); step(1);
        check("t5_after_rst", gnt_a, 4'b0001);
        step(3);

        // Two requesters alternating; exercises the HOLD_MAX=1 instance.
        req = 4'b1001; step(12);

        // Randomized traffic with occasional enable drops.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            ena = ($urandom_range(0, 7) != 0);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
